// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_if
//  Brief    : Producer/consumer handshake bundle for sync_fifo. The producer
//             side (s_*) writes words, the consumer side (m_*) takes the head
//             word, plus occupancy status.
//  Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    // Producer side
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [DATA_WIDTH-1:0]   s_data_i;

    // Consumer side
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic [DATA_WIDTH-1:0]   m_data_o;

    // Status
    logic [$clog2(DEPTH):0]  count_o;
    logic                    almost_full_o;

    // The environment that feeds and drains the FIFO
    modport master (
        output s_valid_i,
        output s_data_i,
        output m_ready_i,
        input  s_ready_o,
        input  m_valid_o,
        input  m_data_o,
        input  count_o,
        input  almost_full_o
    );

    // The FIFO itself
    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  m_ready_i,
        output s_ready_o,
        output m_valid_o,
        output m_data_o,
        output count_o,
        output almost_full_o
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO with valid/ready on
//             both sides. The head word is presented on m_data_o as soon as
//             it is stored; occupancy and almost-full come from a dedicated
//             count register so every status output is registered-derived.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    sync_fifo_if.slave       bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_AF   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    // Storage is deliberately not reset; the count register alone decides
    // which entries are live.
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    // Status decodes from the count register only, so no handshake input
    // reaches a ready/valid output combinationally.
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == c_CNT_ZERO);

    // Gating push with rstn_i keeps the array untouched while in reset,
    // matching the forced-low s_ready_o the producer sees.
    assign w_push = bus.s_valid_i & ~w_full & rstn_i;
    assign w_pop  = bus.m_ready_i & ~w_empty;

    // Write the accepted word into the slot under the write pointer.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.s_data_i;
        end
    end

    // Write pointer advances once per accepted word and wraps naturally.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    // Read pointer advances once per word taken by the consumer.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Occupancy: a simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    // rstn_i is the one input allowed straight through to an output, so the
    // producer sees not-ready for the whole time reset is held.
    assign bus.s_ready_o     = ~w_full & rstn_i;
    assign bus.m_valid_o     = ~w_empty;
    assign bus.m_data_o      = r_mem[r_rd_ptr];
    assign bus.count_o       = r_count;
    assign bus.almost_full_o = (r_count >= c_CNT_AF);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Brief    : Directed self-checking bench for sync_fifo (DEPTH 8, 32-bit,
//             AF_LEVEL 6). Inputs are driven and outputs sampled on the
//             falling edge of the clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    sync_fifo_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

    sync_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .AF_LEVEL   (6)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: every wait below is a fixed cycle count, this only guards
    // against a stalled simulator.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rstn          = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_s_ready cyc=%0d got %b want 0", i, bus.s_ready_o);
            end
            checks++;
            if (bus.m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_m_valid cyc=%0d got %b want 0", i, bus.m_valid_o);
            end
            checks++;
            if (bus.count_o !== 4'd0) begin
                errors++;
                $display("FAIL reset_count cyc=%0d got %0d want 0", i, bus.count_o);
            end
            checks++;
            if (bus.almost_full_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_almost_full cyc=%0d got %b want 0", i, bus.almost_full_o);
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL release_s_ready got %b want 1", bus.s_ready_o);
        end
        checks++;
        if (bus.count_o !== 4'd0) begin
            errors++;
            $display("FAIL release_count got %0d want 0", bus.count_o);
        end
    endtask

    task automatic test_fill_drain();
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 32'hAAAA0000 + 32'(i);
            @(negedge clk);
            checks++;
            if (bus.count_o !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_count push=%0d got %0d want %0d", i, bus.count_o, i + 1);
            end
            checks++;
            if (bus.almost_full_o !== ((i + 1) >= 6)) begin
                errors++;
                $display("FAIL fill_almost_full push=%0d got %b want %b", i,
                         bus.almost_full_o, ((i + 1) >= 6));
            end
        end
        checks++;
        if (bus.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_s_ready got %b want 0", bus.s_ready_o);
        end
        // Ninth word must bounce off a full FIFO.
        bus.s_data_i = 32'hDEAD0000;
        @(negedge clk);
        checks++;
        if (bus.count_o !== 4'd8) begin
            errors++;
            $display("FAIL overflow_count got %0d want 8", bus.count_o);
        end
        checks++;
        if (bus.m_data_o !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL overflow_head got %h want aaaa0000", bus.m_data_o);
        end
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 32'hAAAA0000 + 32'(i)) begin
                errors++;
                $display("FAIL drain_word idx=%0d got v=%b d=%h want v=1 d=%h", i,
                         bus.m_valid_o, bus.m_data_o, 32'hAAAA0000 + 32'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.count_o !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b cnt=%0d want v=0 cnt=0",
                     bus.m_valid_o, bus.count_o);
        end
        bus.m_ready_i = 1'b0;
    endtask

    task automatic test_streaming();
        bus.s_valid_i = 1'b1;
        bus.m_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.s_data_i = 32'(k);
            @(negedge clk);
            checks++;
            if (bus.count_o !== 4'd1 || bus.m_valid_o !== 1'b1 || bus.m_data_o !== 32'(k)) begin
                errors++;
                $display("FAIL stream_word k=%0d got cnt=%0d v=%b d=%h want cnt=1 v=1 d=%h",
                         k, bus.count_o, bus.m_valid_o, bus.m_data_o, 32'(k));
            end
        end
        bus.s_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count_o !== 4'd0 || bus.m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_tail got cnt=%0d v=%b want cnt=0 v=0",
                     bus.count_o, bus.m_valid_o);
        end
        bus.m_ready_i = 1'b0;
    endtask

    task automatic test_full_push_pop();
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 32'hAAAA0000 + 32'(i);
            @(negedge clk);
        end
        checks++;
        if (bus.count_o !== 4'd8) begin
            errors++;
            $display("FAIL refill_count got %0d want 8", bus.count_o);
        end
        // Push and pop together while full: only the pop takes effect.
        bus.s_data_i  = 32'hBBBB0000;
        bus.m_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count_o !== 4'd7 || bus.s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_state got cnt=%0d rdy=%b want cnt=7 rdy=1",
                     bus.count_o, bus.s_ready_o);
        end
        checks++;
        if (bus.m_data_o !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL full_pp_head got %h want aaaa0001", bus.m_data_o);
        end
        bus.m_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count_o !== 4'd8) begin
            errors++;
            $display("FAIL full_pp_retry got %0d want 8", bus.count_o);
        end
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_word;
            exp_word = (i < 7) ? (32'hAAAA0001 + 32'(i)) : 32'hBBBB0000;
            checks++;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== exp_word) begin
                errors++;
                $display("FAIL full_pp_drain idx=%0d got v=%b d=%h want v=1 d=%h",
                         i, bus.m_valid_o, bus.m_data_o, exp_word);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.count_o !== 4'd0 || bus.m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pp_empty got cnt=%0d v=%b want cnt=0 v=0",
                     bus.count_o, bus.m_valid_o);
        end
        bus.m_ready_i = 1'b0;
    endtask

    task automatic test_empty_pop();
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.count_o !== 4'd0 || bus.m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL empty_pop cyc=%0d got cnt=%0d v=%b want cnt=0 v=0",
                         i, bus.count_o, bus.m_valid_o);
            end
        end
        bus.m_ready_i = 1'b0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'h12345678;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        checks++;
        if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 32'h12345678 || bus.count_o !== 4'd1) begin
            errors++;
            $display("FAIL empty_push got v=%b d=%h cnt=%0d want v=1 d=12345678 cnt=1",
                     bus.m_valid_o, bus.m_data_o, bus.count_o);
        end
        bus.m_ready_i = 1'b1;
        @(negedge clk);
        bus.m_ready_i = 1'b0;
        checks++;
        if (bus.count_o !== 4'd0) begin
            errors++;
            $display("FAIL empty_push_pop got %0d want 0", bus.count_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 32'h55550000 + 32'(i);
            @(negedge clk);
        end
        bus.s_valid_i = 1'b0;
        checks++;
        if (bus.count_o !== 4'd5) begin
            errors++;
            $display("FAIL midrst_pre_count got %0d want 5", bus.count_o);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count_o !== 4'd0 || bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=0",
                     bus.count_o, bus.m_valid_o, bus.s_ready_o);
        end
        rstn          = 1'b1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'hCAFE0001;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        checks++;
        if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 32'hCAFE0001 || bus.count_o !== 4'd1) begin
            errors++;
            $display("FAIL midrst_first got v=%b d=%h cnt=%0d want v=1 d=cafe0001 cnt=1",
                     bus.m_valid_o, bus.m_data_o, bus.count_o);
        end
        checks++;
        if (bus.almost_full_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_almost_full got %b want 0", bus.almost_full_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_push_pop();
        test_empty_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
